// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl -- load/store unit between the EXU and the data-memory bus.
//
// Accepts one load or store per transaction from the core, runs it as a
// single word-wide access on a valid/ready memory bus and returns exactly one
// response. Store data is lane-shifted and byte strobes are built from the
// lane mask. Load data is shifted down and then sign- or zero-extended.
// Misaligned, illegal, or conflicting requests are answered with an error
// and never reach the bus.
//
// Optional build macro: LSU_TIMEOUT_EN
//   Bounds the memory wait to TIMEOUT_CYCLES cycles spent in REQ/WAIT.
//   On expiry the unit answers with an error. A late bus response is dropped.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   core request handshake (ready only while idle)
//   req_wen/req_ren       store / load select (exactly one must be set)
//   req_addr       byte address
//   req_wdata      store data, LSB-aligned
//   req_wmask      store lane mask before shifting (01 byte, 03 half, 0F word)
//   req_rmask      load funct3 (LB, LH, LW, LBU, LHU)
//   rsp_valid      one-cycle response pulse with rsp_rdata / rsp_err
//   mem_req_valid/mem_req_ready  bus request handshake
//   mem_we, mem_addr, mem_wdata, mem_wstrb  bus request payload (word address)
//   mem_rsp_valid, mem_rdata     bus response (read data or write ack)
module lsu_mem_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic              req_ren,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_wmask,
  input  logic [2:0]        req_rmask,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        wmask_q;
  logic [2:0]        rmask_q;
  logic              we_q;
  logic              err_q;
  logic              req_ok;
  logic              accept;
  logic              mem_done;
  logic              tmo_hit;
  logic              tmo_abort;

  // Sign/zero extension of a lane-aligned load word according to funct3.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [2:0]        funct3);
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [DATA_W-1:0] ext;
    b = word[7:0];
    h = word[15:0];
    case (funct3)
      3'b000:  ext = DATA_W'(b);
      3'b001:  ext = DATA_W'(h);
      3'b100:  ext = DATA_W'(word[7:0]);
      3'b101:  ext = DATA_W'(word[15:0]);
      default: ext = word;
    endcase
    return ext;
  endfunction

  // Legality: exactly one of wen/ren, a known size code, natural alignment.
  always_comb begin
    req_ok = 1'b0;
    if (req_wen && !req_ren) begin
      case (req_wmask)
        8'h01:   req_ok = 1'b1;
        8'h03:   req_ok = !req_addr[0];
        8'h0F:   req_ok = (req_addr[1:0] == 2'b00);
        default: req_ok = 1'b0;
      endcase
    end else if (req_ren && !req_wen) begin
      case (req_rmask)
        3'b000, 3'b100: req_ok = 1'b1;
        3'b001, 3'b101: req_ok = !req_addr[0];
        3'b010:         req_ok = (req_addr[1:0] == 2'b00);
        default:        req_ok = 1'b0;
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  // Held at zero while idle, so it starts from zero on every entry to REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == ST_REQ || state_q == ST_WAIT) &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    mem_done      = 1'b0;
    tmo_abort     = 1'b0;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rdata     = '0;
    rsp_err       = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = req_ok ? ST_REQ : ST_RESP;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        mem_we        = we_q;
        mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
        if (we_q) begin
          mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
          mem_wstrb = wmask_q << addr_q[1:0];
        end
        // A handshake in the same cycle as expiry wins over the timeout.
        if (mem_req_ready) begin
          state_d = ST_WAIT;
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          mem_done = 1'b1;
          state_d  = ST_RESP;
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage boundary: control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage boundary: request payload and response data registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask[3:0];
      rmask_q <= req_rmask;
      we_q    <= req_wen;
      rdata_q <= '0;
      err_q   <= !req_ok;
    end else if (mem_done) begin
      rdata_q <= we_q ? '0 : load_extend(mem_rdata >> {addr_q[1:0], 3'b000}, rmask_q);
      err_q   <= 1'b0;
    end else if (tmo_abort) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic              req_ren;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [7:0]        req_wmask;
  logic [2:0]        req_rmask;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  int n_checks;
  int n_fail;
  logic [31:0] mem_model [16];

  lsu_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_ren(req_ren), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_rmask(req_rmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Access size in bytes, 0 when the request itself is illegal.
  function automatic int access_size(input logic wen, input logic ren,
                                     input logic [7:0] wmask, input logic [2:0] rmask);
    if (wen == ren) return 0;
    if (wen) begin
      if (wmask == 8'h01) return 1;
      if (wmask == 8'h03) return 2;
      if (wmask == 8'h0F) return 4;
      return 0;
    end
    if (rmask == 3'd0 || rmask == 3'd4) return 1;
    if (rmask == 3'd1 || rmask == 3'd5) return 2;
    if (rmask == 3'd2) return 4;
    return 0;
  endfunction

  task automatic run_txn(input logic wen, input logic ren, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [7:0] wmask,
                         input logic [2:0] rmask, input int rdy_dly, input int rsp_dly,
                         output logic [31:0] got_rdata);
    int          size, off, idx;
    logic        err;
    logic [31:0] exp_wdata, exp_rdata, word, lane_mask;
    logic [3:0]  exp_strb;
    size = access_size(wen, ren, wmask, rmask);
    err  = (size == 0) || ((addr % size) != 0);
    off  = addr % 4;
    idx  = (addr / 4) % 16;
    got_rdata = 32'hx;
    check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wen = wen; req_ren = ren; req_addr = addr;
    req_wdata = wdata; req_wmask = wmask; req_rmask = rmask;
    step();
    req_valid = 1'b0;
    if (err) begin
      check_eq("err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("err_rsp_err", {31'd0, rsp_err}, 32'd1);
      check_eq("err_rsp_rdata", rsp_rdata, 32'd0);
      check_eq("err_no_bus", {31'd0, mem_req_valid}, 32'd0);
      got_rdata = rsp_rdata;
    end else begin
      exp_wdata = wdata << (8 * off);
      exp_strb  = 4'(((1 << size) - 1) << off);
      for (int c = 0; c <= rdy_dly; c++) begin
        check_eq("mem_req_valid", {31'd0, mem_req_valid}, 32'd1);
        check_eq("mem_we", {31'd0, mem_we}, {31'd0, wen});
        check_eq("mem_addr", mem_addr, addr - 32'(off));
        if (wen) begin
          check_eq("mem_wdata", mem_wdata, exp_wdata);
          check_eq("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_strb});
        end
        check_eq("busy_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("busy_req_ready", {31'd0, req_ready}, 32'd0);
        mem_req_ready = (c == rdy_dly);
        mem_rsp_valid = (c == 0) && (rdy_dly > 0);
        mem_rdata     = $urandom;
        step();
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      for (int c = 0; c < rsp_dly; c++) begin
        check_eq("wait_no_bus", {31'd0, mem_req_valid}, 32'd0);
        check_eq("wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step();
      end
      mem_rsp_valid = 1'b1;
      mem_rdata     = wen ? $urandom : mem_model[idx];
      step();
      mem_rsp_valid = 1'b0;
      if (wen) begin
        exp_rdata = 32'd0;
        for (int k = 0; k < size; k++)
          mem_model[idx][8*(off+k) +: 8] = wdata[8*k +: 8];
      end else begin
        word = mem_model[idx] >> (8 * off);
        if (size < 4) begin
          lane_mask = (32'd1 << (8 * size)) - 32'd1;
          exp_rdata = word & lane_mask;
          if ((rmask == 3'd0 || rmask == 3'd1) && exp_rdata[8*size-1])
            exp_rdata = exp_rdata | ~lane_mask;
        end else begin
          exp_rdata = word;
        end
      end
      check_eq("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("rsp_err", {31'd0, rsp_err}, 32'd0);
      check_eq("rsp_rdata", rsp_rdata, exp_rdata);
      got_rdata = rsp_rdata;
    end
    step();
    check_eq("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
  endtask

  logic [31:0] got;
  int          lat;

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_ren = 1'b0;
    req_addr = '0; req_wdata = '0; req_wmask = '0; req_rmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    step(); step();
    check_eq("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("reset_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check_eq("reset_mem_we", {31'd0, mem_we}, 32'd0);
    check_eq("reset_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    rst = 1'b0;
    step();

    // Directed cases with literal expectations.
    mem_model[1] = 32'hDEAD_BEEF;
    run_txn(1'b0, 1'b1, 32'h8000_0004, 32'd0, 8'h00, 3'b010, 0, 0, got);
    check_eq("lw_literal", got, 32'hDEAD_BEEF);
    mem_model[0] = 32'h8011_2233;
    run_txn(1'b0, 1'b1, 32'h8000_0003, 32'd0, 8'h00, 3'b000, 0, 0, got);
    check_eq("lb_literal", got, 32'hFFFF_FF80);
    run_txn(1'b0, 1'b1, 32'h8000_0003, 32'd0, 8'h00, 3'b100, 0, 0, got);
    check_eq("lbu_literal", got, 32'h0000_0080);
    run_txn(1'b0, 1'b1, 32'h8000_0002, 32'd0, 8'h00, 3'b101, 0, 0, got);
    check_eq("lhu_literal", got, 32'h0000_8011);
    run_txn(1'b1, 1'b0, 32'h8000_0001, 32'h0000_00AB, 8'h01, 3'b000, 0, 0, got);
    run_txn(1'b0, 1'b1, 32'h8000_0000, 32'd0, 8'h00, 3'b010, 0, 0, got);
    check_eq("sb_merge", got, 32'h8011_AB33);
    run_txn(1'b1, 1'b0, 32'h8000_0003, 32'h1234, 8'h03, 3'b000, 0, 0, got);
    run_txn(1'b0, 1'b1, 32'h8000_0002, 32'd0, 8'h00, 3'b010, 0, 0, got);
    run_txn(1'b1, 1'b1, 32'h8000_0000, 32'd0, 8'h01, 3'b000, 0, 0, got);
    run_txn(1'b0, 1'b0, 32'h8000_0000, 32'd0, 8'h01, 3'b000, 0, 0, got);
    run_txn(1'b0, 1'b1, 32'h8000_0000, 32'd0, 8'h00, 3'b011, 0, 0, got);
    run_txn(1'b1, 1'b0, 32'h8000_0000, 32'd0, 8'h07, 3'b000, 0, 0, got);
    run_txn(1'b1, 1'b0, 32'h8000_0008, 32'hCAFE_F00D, 8'h0F, 3'b000, 5, 2, got);

    // Reset while waiting for the bus response.
    req_valid = 1'b1; req_wen = 1'b0; req_ren = 1'b1;
    req_addr = 32'h8000_0004; req_rmask = 3'b010;
    step();
    req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_no_bus", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_rsp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_eq("stale_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check_eq("stale_req_ready", {31'd0, req_ready}, 32'd1);
      step();
    end

`ifdef LSU_TIMEOUT_EN
    req_valid = 1'b1; req_wen = 1'b0; req_ren = 1'b1;
    req_addr = 32'h8000_0010; req_rmask = 3'b010;
    step();
    req_valid = 1'b0; mem_req_ready = 1'b1; lat = 1;
    while (!rsp_valid && lat < 30) begin
      step();
      mem_req_ready = 1'b0;
      lat++;
    end
    check_eq("tmo_latency", 32'(lat), 32'd9);
    check_eq("tmo_err", {31'd0, rsp_err}, 32'd1);
    check_eq("tmo_rdata", rsp_rdata, 32'd0);
    step();
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    check_eq("tmo_late_dropped", {31'd0, rsp_valid}, 32'd0);
    step();
`else
    lat = 0;
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic        w, r;
      logic [7:0]  wm;
      logic [2:0]  rm;
      logic [31:0] a;
      int          kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        w = 1'($urandom); r = w;
      end else begin
        w = (kind < 5); r = !w;
      end
      case ($urandom_range(0, 7))
        0, 1, 2: wm = 8'h01;
        3, 4:    wm = 8'h03;
        5, 6:    wm = 8'h0F;
        default: wm = 8'($urandom);
      endcase
      rm = 3'($urandom);
      a  = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      run_txn(w, r, a, $urandom, wm, rm, $urandom_range(0, 3), $urandom_range(0, 3), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
